// File: rtl/vout_timing_gen_if.sv
`timescale 1ns/1ps
// Pixel stream between the frame-buffer CDC FIFO read side and the output timing generator.
// Word layout: {sof, r[7:0], g[7:0], b[7:0]}; a word moves when s_val_i & s_rdy_o.
interface vout_timing_gen_if;
   logic        s_val_i;
   logic [24:0] s_data_i;
   logic        s_rdy_o;

   modport master (output s_val_i, output s_data_i, input s_rdy_o);
   modport slave  (input s_val_i, input s_data_i, output s_rdy_o);
endinterface

// File: rtl/vout_timing_gen.sv
`timescale 1ns/1ps
// vout_timing_gen: HDMI output raster (HS/VS/DE) that pulls frame-aligned pixels from a stream.
// Build macro VOUT_INVERT_EN adds is_light_i and per-frame inversion of active RGB.
module vout_timing_gen #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
`ifdef VOUT_INVERT_EN
   input  logic                    is_light_i,
`endif
   vout_timing_gen_if.slave        s_if,
   output logic                    vout_hs_o,
   output logic                    vout_vs_o,
   output logic                    vout_de_o,
   output logic [23:0]             vout_data_o,
   output logic                    frame_o,
   output logic                    locked_o,
   output logic                    underflow_o
);
   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);

   typedef enum logic {SEEK = 1'b0, RUN = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          hs_q, vs_q, de_q, frame_q, uf_q, uf_d;
   logic [23:0]   data_q, data_d;
   logic          rdy;
   logic          active, hs_on, vs_on, h_last, frame_end, sof;
   logic [23:0]   rgb_out;

   assign sof       = s_if.s_data_i[24];
   assign active    = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
   assign hs_on     = (int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                      (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
   assign vs_on     = (int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                      (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);
   assign h_last    = (int'(h_cnt_q) == H_TOT - 1);
   assign frame_end = h_last && (int'(v_cnt_q) == V_TOT - 1);

`ifdef VOUT_INVERT_EN
   // Inversion choice is latched once per frame, on the cycle before pixel (0,0).
   logic inv_q;
   assign rgb_out = inv_q ? ~s_if.s_data_i[23:0] : s_if.s_data_i[23:0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)          inv_q <= 1'b0;
      else if (frame_end) inv_q <= is_light_i;
   end
`else
   assign rgb_out = s_if.s_data_i[23:0];
`endif

   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_last) begin
         h_cnt_d = '0;
         v_cnt_d = frame_end ? '0 : v_cnt_q + 1'b1;
      end
   end

   // SEEK flushes non-sof words and holds a sof word until the frame boundary.
   always_comb begin
      state_d = state_q;
      rdy     = 1'b0;
      data_d  = '0;
      uf_d    = uf_q;
      case (state_q)
         SEEK: begin
            rdy = s_if.s_val_i & ~sof;
            if (frame_end && s_if.s_val_i && sof) state_d = RUN;
         end
         RUN: begin
            rdy = active;
            if (active) begin
               if (s_if.s_val_i) begin
                  data_d = rgb_out;
               end else begin
                  uf_d    = 1'b1;
                  state_d = SEEK;
               end
            end
         end
         default: state_d = SEEK;
      endcase
   end

   assign s_if.s_rdy_o = rdy & ~rst_i;
   assign locked_o     = (state_q == RUN);
   assign underflow_o  = uf_q;
   assign vout_hs_o    = hs_q;
   assign vout_vs_o    = vs_q;
   assign vout_de_o    = de_q;
   assign vout_data_o  = data_q;
   assign frame_o      = frame_q;

   // Output stage: one cycle behind the counters and the pop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         state_q <= SEEK;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         de_q    <= 1'b0;
         data_q  <= '0;
         frame_q <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         state_q <= state_d;
         hs_q    <= hs_on ? HS_POL : ~HS_POL;
         vs_q    <= vs_on ? VS_POL : ~VS_POL;
         de_q    <= active;
         data_q  <= data_d;
         frame_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
         uf_q    <= uf_d;
      end
   end
endmodule
